// File: rtl/alu_issue_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_arbiter_pkg
// Brief    : ALU opcode set, requester owner encoding and idle ALU drive value
//            shared by the ALU issue arbiter and its tag pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package alu_issue_arbiter_pkg;

  localparam logic [3:0] ALUOP_ADD  = 4'd0;
  localparam logic [3:0] ALUOP_SUB  = 4'd1;
  localparam logic [3:0] ALUOP_SLL  = 4'd2;
  localparam logic [3:0] ALUOP_SLT  = 4'd3;
  localparam logic [3:0] ALUOP_SLTU = 4'd4;
  localparam logic [3:0] ALUOP_XOR  = 4'd5;
  localparam logic [3:0] ALUOP_SRL  = 4'd6;
  localparam logic [3:0] ALUOP_SRA  = 4'd7;
  localparam logic [3:0] ALUOP_OR   = 4'd8;
  localparam logic [3:0] ALUOP_AND  = 4'd9;

  typedef logic owner_t;

  localparam owner_t REQ0 = 1'b0;
  localparam owner_t REQ1 = 1'b1;

  localparam logic [3:0] ALU_IDLE_OPSEL = ALUOP_ADD;

endpackage
`default_nettype wire

// File: rtl/alu_issue_arbiter_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_tag_pipe
// Brief    : LATENCY-deep {valid, owner, tag} shift register with a per-owner
//            kill that drops matching entries on the next edge.
// Revision : 1.0 - initial release
// ============================================================================
module alu_tag_pipe
  import alu_issue_arbiter_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load_valid,
  input  logic             i_load_owner,
  input  logic [TAG_W-1:0] i_load_tag,
  input  logic [1:0]       i_kill,
  output logic             o_last_valid,
  output logic             o_last_owner,
  output logic [TAG_W-1:0] o_last_tag,
  output logic             o_any_valid
);

  logic [LATENCY-1:0]            valid_q, valid_d;
  logic [LATENCY-1:0]            owner_q, owner_d;
  logic [LATENCY-1:0][TAG_W-1:0] tag_q, tag_d;

  // A killed entry is dropped as it shifts, so the kill lands on the next edge.
  genvar g;
  generate
    for (g = 0; g < LATENCY; g++) begin : g_stage
      if (g == 0) begin : g_head
        assign valid_d[g] = i_load_valid && !i_kill[i_load_owner];
        assign owner_d[g] = i_load_owner;
        assign tag_d[g]   = i_load_tag;
      end else begin : g_body
        assign valid_d[g] = valid_q[g-1] && !i_kill[owner_q[g-1]];
        assign owner_d[g] = owner_q[g-1];
        assign tag_d[g]   = tag_q[g-1];
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q <= '0;
      owner_q <= {LATENCY{REQ0}};
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
      tag_q   <= tag_d;
    end
  end

  assign o_last_valid = valid_q[LATENCY-1];
  assign o_last_owner = owner_q[LATENCY-1];
  assign o_last_tag   = tag_q[LATENCY-1];
  assign o_any_valid  = |valid_q;

endmodule
`default_nettype wire

// File: rtl/alu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_arbiter
// Brief    : Shares one pipelined ALU between two requesters and steers each
//            result back to its owner. Define ALU_ARB_RR_EN for round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_arbiter
  import alu_issue_arbiter_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [31:0]      i_req0_op1,
  input  logic [31:0]      i_req0_op2,
  input  logic [3:0]       i_req0_opsel,
  input  logic [TAG_W-1:0] i_req0_tag,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [31:0]      i_req1_op1,
  input  logic [31:0]      i_req1_op2,
  input  logic [3:0]       i_req1_opsel,
  input  logic [TAG_W-1:0] i_req1_tag,
  input  logic             i_flush0,
  output logic [31:0]      o_alu_op1,
  output logic [31:0]      o_alu_op2,
  output logic [3:0]       o_alu_opsel,
  input  logic [31:0]      i_alu_result,
  output logic             o_rsp0_valid,
  output logic             o_rsp1_valid,
  output logic [31:0]      o_rsp_data,
  output logic [TAG_W-1:0] o_rsp_tag,
  output logic             o_busy
);

  logic             w_elig0, w_elig1;
  logic             w_grant0, w_grant1;
  logic             w_last_valid, w_last_owner;
  logic [TAG_W-1:0] w_last_tag;
  logic             w_rsp_live;

  assign w_elig0 = i_req0_valid && !i_flush0 && !i_reset;
  assign w_elig1 = i_req1_valid && !i_reset;

`ifdef ALU_ARB_RR_EN
  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (w_grant0)      ptr_d = REQ1;
    else if (w_grant1) ptr_d = REQ0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) ptr_q <= REQ0;
    else         ptr_q <= ptr_d;
  end

  assign w_grant0 = w_elig0 && (!w_elig1 || ptr_q == REQ0);
`else
  assign w_grant0 = w_elig0;
`endif
  assign w_grant1 = w_elig1 && !w_grant0;

  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;

  // Idle drive keeps the ALU computing a defined value in unused slots.
  always_comb begin
    o_alu_op1   = 32'd0;
    o_alu_op2   = 32'd0;
    o_alu_opsel = ALU_IDLE_OPSEL;
    if (w_grant0) begin
      o_alu_op1   = i_req0_op1;
      o_alu_op2   = i_req0_op2;
      o_alu_opsel = i_req0_opsel;
    end else if (w_grant1) begin
      o_alu_op1   = i_req1_op1;
      o_alu_op2   = i_req1_op2;
      o_alu_opsel = i_req1_opsel;
    end
  end

  alu_tag_pipe #(
    .LATENCY (LATENCY),
    .TAG_W   (TAG_W)
  ) u_tag_pipe (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load_valid (w_grant0 || w_grant1),
    .i_load_owner (w_grant1 ? REQ1 : REQ0),
    .i_load_tag   (w_grant1 ? i_req1_tag : i_req0_tag),
    .i_kill       ({1'b0, i_flush0}),
    .o_last_valid (w_last_valid),
    .o_last_owner (w_last_owner),
    .o_last_tag   (w_last_tag),
    .o_any_valid  (o_busy)
  );

  // A flush suppresses a requester-0 result already in its response cycle.
  assign w_rsp_live = w_last_valid && !i_reset
                      && !(w_last_owner == REQ0 && i_flush0);

  assign o_rsp0_valid = w_rsp_live && w_last_owner == REQ0;
  assign o_rsp1_valid = w_rsp_live && w_last_owner == REQ1;
  assign o_rsp_data   = w_rsp_live ? i_alu_result : 32'd0;
  assign o_rsp_tag    = w_rsp_live ? w_last_tag : '0;

endmodule
`default_nettype wire
